mc_sequencer: RTL and testbench
===============================

// Module: mc_sequencer
// PURPOSE
//   Multicycle RV32I control FSM. Sequences the shared datapath (single memory port, one ALU, register file, imm extender)
//   through fetch/decode/execute/writeback, one state per clock.
//   Decodes the latched instruction and drives every datapath select and strobe.
//   Sits beside the datapath in top; takes opcode fields from the instruction register and flags from the ALU.
// PARAMETERS
//   ALU_CTRL_W  4  width of alu_control
//   STATE_W     4  width of state register / dbg_state
// PORTS
//   clk            in   1   system clock; sole clock domain
//   reset          in   1   synchronous, active-high; forces FETCH
//   op             in   7   instr[6:0] from instruction register
//   funct3         in   3   instr[14:12]
//   funct7b5       in   1   instr[30]
//   zero           in   1   ALU result == 0
//   sign           in   1   ALU result[31]
//   carry          in   1   ALU carry-out; 1 = no borrow on SUB (a >= b unsigned)
//   overflow       in   1   ALU signed overflow
//   pc_write       out  1   load PC from result
//   adr_src        out  1   memory address: 0 = pc, 1 = result
//   mem_write      out  1   dmem write strobe
//   ir_write       out  1   latch instr and old_pc
//   result_src     out  2   00 alu_reg, 01 mem data, 10 alu_result
//   alu_control    out  ALU_CTRL_W  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU,10 PASSB
//   alu_src_a      out  2   00 pc, 01 old_pc, 10 rd1 (11 never driven)
//   alu_src_b      out  2   00 rd2, 01 imm_ext, 10 const 4 (11 never driven)
//   imm_src        out  3   000 I, 001 S, 010 B, 011 J, 100 U
//   reg_write      out  1   register file write enable
//   illegal_instr  out  1   one-cycle pulse: unsupported opcode seen in DECODE
//   dbg_state      out  STATE_W  current state encoding
// BEHAVIOUR
//   Moore FSM; outputs combinational from state + latched fields. Selects not listed for a state are don't-care;
//   strobes not listed are 0.
//   While reset=1: state<=FETCH next edge; pc_write, mem_write, ir_write, reg_write, illegal_instr forced 0; dbg_state=0.
//   Reset mid-instruction abandons it; no write strobe fires in the reset cycle.
//   States/outputs:
//   FETCH(0): adr_src=0, ir_write=1, a=pc, b=4, ADD, result_src=10, pc_write=1 -> DECODE.
//   DECODE(1): a=old_pc, b=imm(B), ADD (branch target into alu_reg). Next by op:
//     0000011 MEMADR; 0100011 MEMADR; 0110011 EXEC_R; 0010011 EXEC_I; 1100011 BRANCH; 1101111 JAL;
//     1100111 JALR; 0110111 LUI; 0010111 AUIPC; other -> FETCH, illegal_instr=1.
//   MEMADR(2): a=rd1, b=imm (I for load, S for store), ADD -> MEMREAD (load) | MEMWRITE (store).
//   MEMREAD(3): result_src=00, adr_src=1 -> MEMWB.   MEMWB(4): result_src=01, reg_write=1 -> FETCH.
//   MEMWRITE(5): result_src=00, adr_src=1, mem_write=1 -> FETCH.
//   EXEC_R(6): a=rd1, b=rd2, op from funct3 (SUB/SRA when funct7b5=1) -> ALUWB.
//   EXEC_I(7): a=rd1, b=imm(I); funct7b5 only honoured for SRAI (funct3=101); ADDI never SUB -> ALUWB.
//   ALUWB(8): result_src=00, reg_write=1 -> FETCH.
//   BRANCH(9): a=rd1, b=rd2, SUB, result_src=00; pc_write=take where take:
//     BEQ zero, BNE !zero, BLT sign^overflow, BGE !(sign^overflow), BLTU !carry, BGEU carry; funct3 010/011 -> not taken.
//     -> FETCH.
//   JAL(10): a=old_pc, b=4, ADD, result_src=00 (target from DECODE), pc_write=1 -> ALUWB (rd = old_pc+4).
//   JALR(11): a=rd1, b=imm(I), ADD, result_src=10, pc_write=1 -> JALWB.
//   JALWB(12): a=old_pc, b=4, ADD, result_src=10, reg_write=1 -> FETCH.
//   LUI(13): b=imm(U), PASSB -> ALUWB.   AUIPC(14): a=old_pc, b=imm(U), ADD -> ALUWB.
//   State 15 unreachable; if entered -> FETCH with all strobes 0.
//   CPI: load 5, store 4, R/I/LUI/AUIPC 4, branch 3, JAL 4, JALR 4.
//   At most one of mem_write/reg_write high per cycle; ir_write only in FETCH.
// TESTING
//   reset held 3 cycles mid-MEMWRITE -> no mem_write pulse; after release dbg_state=0, ir_write=1 next cycle.
//   op=0000011 from FETCH -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01.
//   op=0110011, funct3=000, funct7b5=1 -> EXEC_R alu_control=1 (SUB); op=0010011 same fields -> alu_control=0.
//   BRANCH funct3=100, sign=1, overflow=0 -> pc_write=1; funct3=110, carry=1 -> pc_write=0.
//   op=1100111 -> JALR pc_write=1 result_src=10; JALWB reg_write=1, a=01, b=10; then FETCH.
//   op=1111111 -> DECODE pulses illegal_instr=1 for one cycle, next state FETCH, no write strobes.

Source files
------------

// File: rtl/mc_sequencer_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath.
// The sequencer takes the master view; the datapath (or a testbench) takes the slave view.
interface mc_sequencer_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int STATE_W    = 4
);
  logic [6:0]            op;
  logic [2:0]            funct3;
  logic                  funct7b5;
  logic                  zero;
  logic                  sign;
  logic                  carry;
  logic                  overflow;

  logic                  pc_write;
  logic                  adr_src;
  logic                  mem_write;
  logic                  ir_write;
  logic [1:0]            result_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [2:0]            imm_src;
  logic                  reg_write;
  logic                  illegal_instr;
  logic [STATE_W-1:0]    dbg_state;

  modport master (
    input  op, funct3, funct7b5, zero, sign, carry, overflow,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
           alu_src_a, alu_src_b, imm_src, reg_write, illegal_instr, dbg_state
  );

  modport slave (
    output op, funct3, funct7b5, zero, sign, carry, overflow,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
           alu_src_a, alu_src_b, imm_src, reg_write, illegal_instr, dbg_state
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle RV32I control FSM: walks the shared datapath through fetch/decode/execute/writeback,
// one state per clock, and decodes every datapath select and strobe from the current state.
module mc_sequencer #(
  parameter int ALU_CTRL_W = 4,
  parameter int STATE_W    = 4
) (
  input logic            clk,
  input logic            reset,
  mc_sequencer_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R, S_EXEC_I,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALWB, S_LUI, S_AUIPC
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = ALU_CTRL_W'(9);
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = ALU_CTRL_W'(10);

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC  = 2'b01;
  localparam logic [1:0] SRC_A_RD1    = 2'b10;
  localparam logic [1:0] SRC_B_RD2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUREG   = 2'b00;
  localparam logic [1:0] RES_MEM      = 2'b01;
  localparam logic [1:0] RES_ALURES   = 2'b10;
  localparam logic [2:0] IMM_I        = 3'b000;
  localparam logic [2:0] IMM_S        = 3'b001;
  localparam logic [2:0] IMM_B        = 3'b010;
  localparam logic [2:0] IMM_U        = 3'b100;

  state_t state_q, state_d;

  logic                  pc_write_c;
  logic                  adr_src_c;
  logic                  mem_write_c;
  logic                  ir_write_c;
  logic [1:0]            result_src_c;
  logic [ALU_CTRL_W-1:0] alu_control_c;
  logic [1:0]            alu_src_a_c;
  logic [1:0]            alu_src_b_c;
  logic [2:0]            imm_src_c;
  logic                  reg_write_c;
  logic                  illegal_c;

  // alt selects SUB/SRA; the caller decides when funct7b5 is meaningful
  function automatic logic [ALU_CTRL_W-1:0] alu_decode(input logic [2:0] f3, input logic alt);
    logic [ALU_CTRL_W-1:0] ctrl;
    case (f3)
      3'b000:  ctrl = alt ? ALU_SUB : ALU_ADD;
      3'b001:  ctrl = ALU_SLL;
      3'b010:  ctrl = ALU_SLT;
      3'b011:  ctrl = ALU_SLTU;
      3'b100:  ctrl = ALU_XOR;
      3'b101:  ctrl = alt ? ALU_SRA : ALU_SRL;
      3'b110:  ctrl = ALU_OR;
      default: ctrl = ALU_AND;
    endcase
    return ctrl;
  endfunction

  // Flags come from rs1 - rs2; carry set means no borrow, i.e. rs1 >= rs2 unsigned
  function automatic logic branch_take(input logic [2:0] f3, input logic z, input logic s,
                                       input logic c, input logic v);
    logic take;
    case (f3)
      3'b000:  take = z;
      3'b001:  take = ~z;
      3'b100:  take = s ^ v;
      3'b101:  take = ~(s ^ v);
      3'b110:  take = ~c;
      3'b111:  take = c;
      default: take = 1'b0;
    endcase
    return take;
  endfunction

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXEC_R, S_EXEC_I, S_JAL, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_JALR:    state_d = S_JALWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    pc_write_c    = 1'b0;
    adr_src_c     = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    result_src_c  = RES_ALUREG;
    alu_control_c = ALU_ADD;
    alu_src_a_c   = SRC_A_PC;
    alu_src_b_c   = SRC_B_RD2;
    imm_src_c     = IMM_I;
    reg_write_c   = 1'b0;
    illegal_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c   = 1'b1;
        alu_src_b_c  = SRC_B_FOUR;
        result_src_c = RES_ALURES;
        pc_write_c   = 1'b1;
      end
      S_DECODE: begin
        // Branch target is precomputed here and parked in alu_reg
        alu_src_a_c = SRC_A_OLDPC;
        alu_src_b_c = SRC_B_IMM;
        imm_src_c   = IMM_B;
        illegal_c   = !(bus.op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
                                       OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});
      end
      S_MEMADR: begin
        alu_src_a_c = SRC_A_RD1;
        alu_src_b_c = SRC_B_IMM;
        imm_src_c   = (bus.op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: adr_src_c = 1'b1;
      S_MEMWB: begin
        result_src_c = RES_MEM;
        reg_write_c  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_c   = SRC_A_RD1;
        alu_control_c = alu_decode(bus.funct3, bus.funct7b5);
      end
      S_EXEC_I: begin
        alu_src_a_c   = SRC_A_RD1;
        alu_src_b_c   = SRC_B_IMM;
        alu_control_c = alu_decode(bus.funct3, bus.funct7b5 && (bus.funct3 == 3'b101));
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a_c   = SRC_A_RD1;
        alu_control_c = ALU_SUB;
        pc_write_c    = branch_take(bus.funct3, bus.zero, bus.sign, bus.carry, bus.overflow);
      end
      S_JAL: begin
        alu_src_a_c = SRC_A_OLDPC;
        alu_src_b_c = SRC_B_FOUR;
        pc_write_c  = 1'b1;
      end
      S_JALR: begin
        alu_src_a_c  = SRC_A_RD1;
        alu_src_b_c  = SRC_B_IMM;
        result_src_c = RES_ALURES;
        pc_write_c   = 1'b1;
      end
      S_JALWB: begin
        alu_src_a_c  = SRC_A_OLDPC;
        alu_src_b_c  = SRC_B_FOUR;
        result_src_c = RES_ALURES;
        reg_write_c  = 1'b1;
      end
      S_LUI: begin
        alu_src_b_c   = SRC_B_IMM;
        imm_src_c     = IMM_U;
        alu_control_c = ALU_PASSB;
      end
      S_AUIPC: begin
        alu_src_a_c = SRC_A_OLDPC;
        alu_src_b_c = SRC_B_IMM;
        imm_src_c   = IMM_U;
      end
      default: ;
    endcase
  end

  // Reset squashes every strobe in the same cycle so an abandoned instruction never writes
  assign bus.pc_write      = pc_write_c  & ~reset;
  assign bus.mem_write     = mem_write_c & ~reset;
  assign bus.ir_write      = ir_write_c  & ~reset;
  assign bus.reg_write     = reg_write_c & ~reset;
  assign bus.illegal_instr = illegal_c   & ~reset;
  assign bus.adr_src       = adr_src_c;
  assign bus.result_src    = result_src_c;
  assign bus.alu_control   = alu_control_c;
  assign bus.alu_src_a     = alu_src_a_c;
  assign bus.alu_src_b     = alu_src_b_c;
  assign bus.imm_src       = imm_src_c;
  assign bus.dbg_state     = reset ? '0 : state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed scenarios plus randomized instruction streams
// compared against an instruction-level reference model of the control sequence.
module tb_mc_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_sequencer_if #(.ALU_CTRL_W(4), .STATE_W(4)) dut_if ();

  mc_sequencer #(.ALU_CTRL_W(4), .STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // One expected cycle; -1 in a select field means the select is free in that state
  typedef struct {
    integer st, pcw, memw, irw, regw, ill, adr, rsrc, alu, a, b, imm;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t blank(input integer st);
    exp_t e;
    e.st = st; e.pcw = 0; e.memw = 0; e.irw = 0; e.regw = 0; e.ill = 0;
    e.adr = -1; e.rsrc = -1; e.alu = -1; e.a = -1; e.b = -1; e.imm = -1;
    return e;
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  // ALU op named by the instruction: ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND; alt gives SUB/SRA
  function automatic integer ref_alu(input logic [2:0] f3, input bit alt);
    case (f3)
      3'd0:    return alt ? 1 : 0;
      3'd1:    return 5;
      3'd2:    return 8;
      3'd3:    return 9;
      3'd4:    return 4;
      3'd5:    return alt ? 7 : 6;
      3'd6:    return 3;
      default: return 2;
    endcase
  endfunction

  // Branch outcome from the actual operand values, not from the ALU flags
  function automatic integer ref_take(input logic [2:0] f3, input logic [31:0] ra, input logic [31:0] rb);
    case (f3)
      3'd0:    return (ra == rb) ? 1 : 0;
      3'd1:    return (ra != rb) ? 1 : 0;
      3'd4:    return ($signed(ra) <  $signed(rb)) ? 1 : 0;
      3'd5:    return ($signed(ra) >= $signed(rb)) ? 1 : 0;
      3'd6:    return (ra <  rb) ? 1 : 0;
      3'd7:    return (ra >= rb) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic build_seq(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                           input logic [31:0] ra, input logic [31:0] rb);
    exp_t e;
    exp_t wb;
    exp_q.delete();
    e = blank(0); e.adr = 0; e.irw = 1; e.a = 0; e.b = 2; e.alu = 0; e.rsrc = 2; e.pcw = 1;
    exp_q.push_back(e);
    e = blank(1); e.a = 1; e.b = 1; e.imm = 2; e.alu = 0; e.ill = is_legal(o) ? 0 : 1;
    exp_q.push_back(e);
    wb = blank(8); wb.rsrc = 0; wb.regw = 1;
    case (o)
      OP_LOAD, OP_STORE: begin
        e = blank(2); e.a = 2; e.b = 1; e.alu = 0; e.imm = (o == OP_STORE) ? 1 : 0;
        exp_q.push_back(e);
        if (o == OP_LOAD) begin
          e = blank(3); e.rsrc = 0; e.adr = 1; exp_q.push_back(e);
          e = blank(4); e.rsrc = 1; e.regw = 1; exp_q.push_back(e);
        end else begin
          e = blank(5); e.rsrc = 0; e.adr = 1; e.memw = 1; exp_q.push_back(e);
        end
      end
      OP_R: begin
        e = blank(6); e.a = 2; e.b = 0; e.alu = ref_alu(f3, f7); exp_q.push_back(e);
        exp_q.push_back(wb);
      end
      OP_I: begin
        e = blank(7); e.a = 2; e.b = 1; e.imm = 0; e.alu = ref_alu(f3, f7 && f3 == 3'd5);
        exp_q.push_back(e);
        exp_q.push_back(wb);
      end
      OP_BRANCH: begin
        e = blank(9); e.a = 2; e.b = 0; e.alu = 1; e.rsrc = 0; e.pcw = ref_take(f3, ra, rb);
        exp_q.push_back(e);
      end
      OP_JAL: begin
        e = blank(10); e.a = 1; e.b = 2; e.alu = 0; e.rsrc = 0; e.pcw = 1; exp_q.push_back(e);
        exp_q.push_back(wb);
      end
      OP_JALR: begin
        e = blank(11); e.a = 2; e.b = 1; e.imm = 0; e.alu = 0; e.rsrc = 2; e.pcw = 1;
        exp_q.push_back(e);
        e = blank(12); e.a = 1; e.b = 2; e.alu = 0; e.rsrc = 2; e.regw = 1; exp_q.push_back(e);
      end
      OP_LUI: begin
        e = blank(13); e.b = 1; e.imm = 4; e.alu = 10; exp_q.push_back(e);
        exp_q.push_back(wb);
      end
      OP_AUIPC: begin
        e = blank(14); e.a = 1; e.b = 1; e.imm = 4; e.alu = 0; exp_q.push_back(e);
        exp_q.push_back(wb);
      end
      default: ;
    endcase
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    dut_if.op = o; dut_if.funct3 = f3; dut_if.funct7b5 = f7;
    dut_if.zero = 1'b0; dut_if.sign = 1'b0; dut_if.carry = 1'b0; dut_if.overflow = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_instr(7'h7F, 3'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_if.dbg_state !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_state: got %0d expected 0", dut_if.dbg_state);
    end
    checks++;
    if ({dut_if.pc_write, dut_if.mem_write, dut_if.ir_write, dut_if.reg_write, dut_if.illegal_instr} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: got %b expected 00000",
        {dut_if.pc_write, dut_if.mem_write, dut_if.ir_write, dut_if.reg_write, dut_if.illegal_instr});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dut_if.dbg_state !== 4'd0 || dut_if.ir_write !== 1'b1 || dut_if.pc_write !== 1'b1) begin
      errors++; $display("[TB] FAIL release_fetch: got state %0d ir_write %b pc_write %b expected 0 1 1",
        dut_if.dbg_state, dut_if.ir_write, dut_if.pc_write);
    end
  endtask

  task automatic test_load();
    int st[5] = '{0, 1, 2, 3, 4};
    set_instr(OP_LOAD, 3'b010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (dut_if.dbg_state !== 4'(st[k])) begin
        errors++; $display("[TB] FAIL load_state step %0d: got %0d expected %0d", k, dut_if.dbg_state, st[k]);
      end
      checks++;
      if (dut_if.reg_write !== (k == 4)) begin
        errors++; $display("[TB] FAIL load_reg_write step %0d: got %b expected %b", k, dut_if.reg_write, k == 4);
      end
      if (k == 4) begin
        checks++;
        if (dut_if.result_src !== 2'b01) begin
          errors++; $display("[TB] FAIL load_result_src: got %b expected 01", dut_if.result_src);
        end
      end
      tick();
    end
    #1;
    checks++;
    if (dut_if.dbg_state !== 4'd0) begin
      errors++; $display("[TB] FAIL load_return: got %0d expected 0", dut_if.dbg_state);
    end
  endtask

  task automatic test_alu_sub();
    set_instr(OP_R, 3'b000, 1'b1);
    tick(); tick(); #1;
    checks++;
    if (dut_if.dbg_state !== 4'd6 || dut_if.alu_control !== 4'd1) begin
      errors++; $display("[TB] FAIL exec_r_sub: got state %0d alu %0d expected 6 1", dut_if.dbg_state, dut_if.alu_control);
    end
    tick(); tick();
    set_instr(OP_I, 3'b000, 1'b1);
    tick(); tick(); #1;
    checks++;
    if (dut_if.dbg_state !== 4'd7 || dut_if.alu_control !== 4'd0) begin
      errors++; $display("[TB] FAIL exec_i_addi: got state %0d alu %0d expected 7 0", dut_if.dbg_state, dut_if.alu_control);
    end
    tick(); tick();
  endtask

  task automatic test_branch();
    set_instr(OP_BRANCH, 3'b100, 1'b0);
    dut_if.sign = 1'b1;
    tick(); tick(); #1;
    checks++;
    if (dut_if.dbg_state !== 4'd9 || dut_if.pc_write !== 1'b1) begin
      errors++; $display("[TB] FAIL blt_taken: got state %0d pc_write %b expected 9 1", dut_if.dbg_state, dut_if.pc_write);
    end
    tick();
    set_instr(OP_BRANCH, 3'b110, 1'b0);
    dut_if.carry = 1'b1;
    tick(); tick(); #1;
    checks++;
    if (dut_if.dbg_state !== 4'd9 || dut_if.pc_write !== 1'b0) begin
      errors++; $display("[TB] FAIL bltu_not_taken: got state %0d pc_write %b expected 9 0", dut_if.dbg_state, dut_if.pc_write);
    end
    tick();
  endtask

  task automatic test_jalr();
    set_instr(OP_JALR, 3'b000, 1'b0);
    tick(); tick(); #1;
    checks++;
    if (dut_if.dbg_state !== 4'd11 || dut_if.pc_write !== 1'b1 || dut_if.result_src !== 2'b10) begin
      errors++; $display("[TB] FAIL jalr: got state %0d pc_write %b result_src %b expected 11 1 10",
        dut_if.dbg_state, dut_if.pc_write, dut_if.result_src);
    end
    tick(); #1;
    checks++;
    if (dut_if.dbg_state !== 4'd12 || dut_if.reg_write !== 1'b1 || dut_if.alu_src_a !== 2'b01 ||
        dut_if.alu_src_b !== 2'b10 || dut_if.pc_write !== 1'b0) begin
      errors++; $display("[TB] FAIL jalwb: got state %0d reg_write %b a %b b %b pc_write %b expected 12 1 01 10 0",
        dut_if.dbg_state, dut_if.reg_write, dut_if.alu_src_a, dut_if.alu_src_b, dut_if.pc_write);
    end
    tick(); #1;
    checks++;
    if (dut_if.dbg_state !== 4'd0) begin
      errors++; $display("[TB] FAIL jalr_return: got %0d expected 0", dut_if.dbg_state);
    end
  endtask

  task automatic test_illegal();
    set_instr(7'b1111111, 3'b000, 1'b0);
    tick(); #1;
    checks++;
    if (dut_if.dbg_state !== 4'd1 || dut_if.illegal_instr !== 1'b1 ||
        {dut_if.pc_write, dut_if.mem_write, dut_if.ir_write, dut_if.reg_write} !== 4'b0) begin
      errors++; $display("[TB] FAIL illegal_decode: got state %0d illegal %b strobes %b expected 1 1 0000",
        dut_if.dbg_state, dut_if.illegal_instr,
        {dut_if.pc_write, dut_if.mem_write, dut_if.ir_write, dut_if.reg_write});
    end
    tick(); #1;
    checks++;
    if (dut_if.dbg_state !== 4'd0 || dut_if.illegal_instr !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_after: got state %0d illegal %b expected 0 0", dut_if.dbg_state, dut_if.illegal_instr);
    end
  endtask

  task automatic test_reset_mid_store();
    set_instr(OP_STORE, 3'b010, 1'b0);
    tick(); tick(); tick(); #1;
    checks++;
    if (dut_if.dbg_state !== 4'd5) begin
      errors++; $display("[TB] FAIL store_reach_memwrite: got %0d expected 5", dut_if.dbg_state);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (dut_if.mem_write !== 1'b0 || dut_if.dbg_state !== 4'd0) begin
        errors++; $display("[TB] FAIL reset_mid_store cycle %0d: got mem_write %b state %0d expected 0 0",
          k, dut_if.mem_write, dut_if.dbg_state);
      end
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dut_if.dbg_state !== 4'd0 || dut_if.ir_write !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid_store_release: got state %0d ir_write %b expected 0 1",
        dut_if.dbg_state, dut_if.ir_write);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops[9] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    string       nm[12] = '{"state", "pc_write", "mem_write", "ir_write", "reg_write", "illegal",
                            "adr_src", "result_src", "alu_control", "alu_src_a", "alu_src_b", "imm_src"};
    logic [6:0]  o;
    logic [2:0]  f3;
    bit          f7;
    logic [31:0] ra, rb, diff;
    exp_t        e;
    integer      ev[12];
    integer      ov[12];
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(7) == 0) begin
        o = 7'h7F;
        for (int t = 0; t < 16; t++) begin
          o = 7'($urandom);
          if (!is_legal(o)) break;
          o = 7'h7F;
        end
      end else begin
        o = ops[$urandom_range(8)];
      end
      f3   = 3'($urandom);
      f7   = 1'($urandom);
      ra   = $urandom;
      rb   = ($urandom_range(3) == 0) ? ra : $urandom;
      diff = ra - rb;
      dut_if.op = o; dut_if.funct3 = f3; dut_if.funct7b5 = f7;
      dut_if.zero     = (diff == 32'd0);
      dut_if.sign     = diff[31];
      dut_if.carry    = (ra >= rb);
      dut_if.overflow = (ra[31] != rb[31]) && (diff[31] != ra[31]);
      build_seq(o, f3, f7, ra, rb);
      for (int k = 0; k < exp_q.size(); k++) begin
        e = exp_q[k];
        #1;
        ev = '{e.st, e.pcw, e.memw, e.irw, e.regw, e.ill, e.adr, e.rsrc, e.alu, e.a, e.b, e.imm};
        ov[0] = dut_if.dbg_state;  ov[1] = dut_if.pc_write;   ov[2]  = dut_if.mem_write;
        ov[3] = dut_if.ir_write;   ov[4] = dut_if.reg_write;  ov[5]  = dut_if.illegal_instr;
        ov[6] = dut_if.adr_src;    ov[7] = dut_if.result_src; ov[8]  = dut_if.alu_control;
        ov[9] = dut_if.alu_src_a;  ov[10] = dut_if.alu_src_b; ov[11] = dut_if.imm_src;
        for (int i = 0; i < 12; i++) begin
          if (ev[i] != -1) begin
            checks++;
            if (ov[i] !== ev[i]) begin
              errors++;
              $display("[TB] FAIL random#%0d op=%b f3=%0d step %0d %s: got %0d expected %0d",
                n, o, f3, k, nm[i], ov[i], ev[i]);
            end
          end
        end
        tick();
      end
    end
    #1;
    checks++;
    if (dut_if.dbg_state !== 4'd0) begin
      errors++; $display("[TB] FAIL random_final_state: got %0d expected 0", dut_if.dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu_sub();
    test_branch();
    test_jalr();
    test_illegal();
    test_reset_mid_store();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
